// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver clocked by a 16x oversampling tick.
//
// The serial line is double-flopped, the start bit is confirmed at mid-bit,
// data bits are sampled LSB-first at bit centres and the stop bit is checked.
// The received byte is handed to the host with a ready/clear handshake.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_enb     one-clk oversampling tick from the baud generator
//   rx         asynchronous serial line, idle high
//   rdy_clr    host acknowledge; clears rdy, frame_err and overrun
//   data       last correctly framed byte
//   rdy        byte available in data
//   frame_err  sticky: stop bit sampled low
//   overrun    sticky: new byte loaded while rdy still set
//   busy       high whenever the receiver is not idle
module uart_rx #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_enb,
   input  logic                 rx,
   input  logic                 rdy_clr,
   output logic [DATA_BITS-1:0] data,
   output logic                 rdy,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);
   localparam int unsigned IW = $clog2(DATA_BITS + 1);

   localparam logic [CW-1:0] CntHalf = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] CntLast = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] IdxLast = IW'(DATA_BITS - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 rdy_q, rdy_d;
   logic                 fe_q, fe_d;
   logic                 ov_q, ov_d;
   logic                 rx_m, rx_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         rdy_q   <= 1'b0;
         fe_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         rdy_q   <= rdy_d;
         fe_q    <= fe_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      data_d  = data_q;
      // Host acknowledge acts every clk; a load or error below overrides it.
      rdy_d   = rdy_q & ~rdy_clr;
      fe_d    = fe_q & ~rdy_clr;
      ov_d    = ov_q & ~rdy_clr;

      if (rx_enb) begin
         case (state_q)
            StIdle: begin
               if (!rx_s) begin
                  state_d = StStart;
                  cnt_d   = '0;
               end
            end
            StStart: begin
               if (cnt_q == CntHalf) begin
                  cnt_d = '0;
                  idx_d = '0;
                  // Line back high at mid-start: a glitch, not a frame.
                  state_d = rx_s ? StIdle : StData;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StData: begin
               if (cnt_q == CntLast) begin
                  shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                  cnt_d   = '0;
                  idx_d   = idx_q + 1'b1;
                  if (idx_q == IdxLast) state_d = StStop;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            StStop: begin
               if (cnt_q == CntLast) begin
                  state_d = StIdle;
                  cnt_d   = '0;
                  if (rx_s) begin
                     data_d = shift_q;
                     rdy_d  = 1'b1;
                     // An acknowledge in this same cycle consumes the old byte.
                     if (rdy_q && !rdy_clr) ov_d = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign data      = data_q;
   assign rdy       = rdy_q;
   assign frame_err = fe_q;
   assign overrun   = ov_q;
   assign busy      = (state_q != StIdle);

endmodule
